// File: rtl/alu_rs_if.sv
// alu_rs_if -- bundle of the ALU reservation-station buses.
//   dispatch : dis_valid/dis_ready handshake plus decoded op, pc, imm,
//              rob slot, destination tag and both source operands
//   cdb      : common-data-bus result broadcast (valid, rob tag, data)
//   flush    : redirect, kills every held entry
//   issue    : alu_i_valid strobe plus the issued instruction fields
// master = the pipeline side that dispatches/broadcasts, slave = the station.
interface alu_rs_if;
  logic        dis_valid;
  logic        dis_ready;
  logic [4:0]  dis_opcode;
  logic [2:0]  dis_funct3;
  logic        dis_funct7;
  logic [31:0] dis_pc;
  logic [31:0] dis_imm;
  logic [2:0]  dis_rob_idx;
  logic [6:0]  dis_rd;
  logic        dis_rs1_rdy;
  logic [2:0]  dis_rs1_tag;
  logic [31:0] dis_rs1_data;
  logic        dis_rs2_rdy;
  logic [2:0]  dis_rs2_tag;
  logic [31:0] dis_rs2_data;

  logic        cdb_valid;
  logic [2:0]  cdb_rob_idx;
  logic [31:0] cdb_data;

  logic        flush;

  logic        alu_i_valid;
  logic [4:0]  alu_opcode;
  logic [2:0]  alu_funct3;
  logic        alu_funct7;
  logic [31:0] alu_pc;
  logic [31:0] alu_imm;
  logic [31:0] alu_rs1_data;
  logic [31:0] alu_rs2_data;
  logic [2:0]  alu_i_rob_idx;
  logic [6:0]  alu_i_rd;

  modport master (
    output dis_valid, dis_opcode, dis_funct3, dis_funct7, dis_pc, dis_imm,
           dis_rob_idx, dis_rd, dis_rs1_rdy, dis_rs1_tag, dis_rs1_data,
           dis_rs2_rdy, dis_rs2_tag, dis_rs2_data,
           cdb_valid, cdb_rob_idx, cdb_data, flush,
    input  dis_ready, alu_i_valid, alu_opcode, alu_funct3, alu_funct7, alu_pc,
           alu_imm, alu_rs1_data, alu_rs2_data, alu_i_rob_idx, alu_i_rd
  );

  modport slave (
    input  dis_valid, dis_opcode, dis_funct3, dis_funct7, dis_pc, dis_imm,
           dis_rob_idx, dis_rd, dis_rs1_rdy, dis_rs1_tag, dis_rs1_data,
           dis_rs2_rdy, dis_rs2_tag, dis_rs2_data,
           cdb_valid, cdb_rob_idx, cdb_data, flush,
    output dis_ready, alu_i_valid, alu_opcode, alu_funct3, alu_funct7, alu_pc,
           alu_imm, alu_rs1_data, alu_rs2_data, alu_i_rob_idx, alu_i_rd
  );
endinterface

// File: rtl/alu_rs.sv
// alu_rs -- out-of-order reservation station for ALU-class instructions.
// Holds up to DEPTH instructions waiting for operands, wakes sources from
// the CDB, and issues the oldest ready entry each cycle to a non-stalling ALU.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears valid, ready flags, age)
//   bus   : alu_rs_if.slave (dispatch, cdb, flush, issue)
module alu_rs #(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_rs_if.slave  bus
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // control state
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] rs1_rdy;
  logic [DEPTH-1:0] rs2_rdy;
  // older[i][j] = 1 means entry j is older than entry i
  logic [DEPTH-1:0] older [DEPTH];

  // payload state (not reset; always qualified by valid/rdy)
  logic [4:0]  opcode   [DEPTH];
  logic [2:0]  funct3   [DEPTH];
  logic        funct7   [DEPTH];
  logic [31:0] pc       [DEPTH];
  logic [31:0] imm      [DEPTH];
  logic [2:0]  rob_idx  [DEPTH];
  logic [6:0]  rd       [DEPTH];
  logic [2:0]  rs1_tag  [DEPTH];
  logic [2:0]  rs2_tag  [DEPTH];
  logic [31:0] rs1_data [DEPTH];
  logic [31:0] rs2_data [DEPTH];

  logic [DEPTH-1:0] elig, sel, wake1, wake2;
  logic [IW-1:0]    free_idx;
  logic             full, alloc;
  logic             rs1_hit, rs2_hit, rs1_rdy_in, rs2_rdy_in;
  logic [31:0]      rs1_data_in, rs2_data_in;

  assign full  = &valid;
  assign alloc = bus.dis_valid && !full && !bus.flush;
  assign elig  = valid & rs1_rdy & rs2_rdy;

  // A source arriving on the CDB in the dispatch cycle is captured directly.
  assign rs1_hit     = bus.cdb_valid && !bus.dis_rs1_rdy && (bus.dis_rs1_tag == bus.cdb_rob_idx);
  assign rs2_hit     = bus.cdb_valid && !bus.dis_rs2_rdy && (bus.dis_rs2_tag == bus.cdb_rob_idx);
  assign rs1_rdy_in  = bus.dis_rs1_rdy | rs1_hit;
  assign rs2_rdy_in  = bus.dis_rs2_rdy | rs2_hit;
  assign rs1_data_in = rs1_hit ? bus.cdb_data : bus.dis_rs1_data;
  assign rs2_data_in = rs2_hit ? bus.cdb_data : bus.dis_rs2_data;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wake1[i] = bus.cdb_valid && valid[i] && !rs1_rdy[i] && (rs1_tag[i] == bus.cdb_rob_idx);
      wake2[i] = bus.cdb_valid && valid[i] && !rs2_rdy[i] && (rs2_tag[i] == bus.cdb_rob_idx);
    end
  end

  // Oldest eligible: no other eligible entry is older than it.
  always_comb begin
    sel = '0;
    if (!bus.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        sel[i] = elig[i] && ((older[i] & elig) == '0);
      end
    end
  end

  // Lowest-index free slot (scan downward so the lowest wins).
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) free_idx = IW'(i);
    end
  end

  // Issue mux; sel is one-hot or zero, so idle outputs are all zero.
  always_comb begin
    bus.alu_opcode    = '0;
    bus.alu_funct3    = '0;
    bus.alu_funct7    = 1'b0;
    bus.alu_pc        = '0;
    bus.alu_imm       = '0;
    bus.alu_rs1_data  = '0;
    bus.alu_rs2_data  = '0;
    bus.alu_i_rob_idx = '0;
    bus.alu_i_rd      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel[i]) begin
        bus.alu_opcode    = opcode[i];
        bus.alu_funct3    = funct3[i];
        bus.alu_funct7    = funct7[i];
        bus.alu_pc        = pc[i];
        bus.alu_imm       = imm[i];
        bus.alu_rs1_data  = rs1_data[i];
        bus.alu_rs2_data  = rs2_data[i];
        bus.alu_i_rob_idx = rob_idx[i];
        bus.alu_i_rd      = rd[i];
      end
    end
  end

  assign bus.alu_i_valid = |sel;
  assign bus.dis_ready   = !full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= '0;
      rs1_rdy <= '0;
      rs2_rdy <= '0;
      for (int i = 0; i < DEPTH; i++) older[i] <= '0;
    end else if (bus.flush) begin
      valid <= '0;
      for (int i = 0; i < DEPTH; i++) older[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (sel[i])   valid[i]   <= 1'b0;
        if (wake1[i]) rs1_rdy[i] <= 1'b1;
        if (wake2[i]) rs2_rdy[i] <= 1'b1;
      end
      if (alloc) begin
        valid[free_idx]   <= 1'b1;
        rs1_rdy[free_idx] <= rs1_rdy_in;
        rs2_rdy[free_idx] <= rs2_rdy_in;
        // New entry is younger than every survivor; its column is cleared so
        // stale bits from a previous occupant of this slot cannot linger.
        older[free_idx] <= valid & ~sel;
        for (int i = 0; i < DEPTH; i++) older[i][free_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wake1[i]) rs1_data[i] <= bus.cdb_data;
      if (wake2[i]) rs2_data[i] <= bus.cdb_data;
    end
    if (alloc) begin
      opcode[free_idx]   <= bus.dis_opcode;
      funct3[free_idx]   <= bus.dis_funct3;
      funct7[free_idx]   <= bus.dis_funct7;
      pc[free_idx]       <= bus.dis_pc;
      imm[free_idx]      <= bus.dis_imm;
      rob_idx[free_idx]  <= bus.dis_rob_idx;
      rd[free_idx]       <= bus.dis_rd;
      rs1_tag[free_idx]  <= bus.dis_rs1_tag;
      rs2_tag[free_idx]  <= bus.dis_rs2_tag;
      rs1_data[free_idx] <= rs1_data_in;
      rs2_data[free_idx] <= rs2_data_in;
    end
  end
endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs -- randomized self-checking bench for alu_rs with an age-ordered
// queue reference model plus directed scenarios.
module tb_alu_rs;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_rs_if bus();
  alu_rs #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [4:0]  opcode;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] pc, imm;
    logic [2:0]  rob;
    logic [6:0]  rd;
    logic        r1, r2;
    logic [2:0]  t1, t2;
    logic [31:0] d1, d2;
  } ent_t;

  typedef struct {
    int          cyc;
    logic [2:0]  rob;
    logic [31:0] d1, d2;
  } iss_t;

  ent_t q[$];       // oldest first
  iss_t log_q[$];   // observed issues
  int total = 0, bad = 0, cyc_n = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.dis_valid = 0; bus.dis_opcode = 0; bus.dis_funct3 = 0; bus.dis_funct7 = 0;
    bus.dis_pc = 0; bus.dis_imm = 0; bus.dis_rob_idx = 0; bus.dis_rd = 0;
    bus.dis_rs1_rdy = 0; bus.dis_rs1_tag = 0; bus.dis_rs1_data = 0;
    bus.dis_rs2_rdy = 0; bus.dis_rs2_tag = 0; bus.dis_rs2_data = 0;
    bus.cdb_valid = 0; bus.cdb_rob_idx = 0; bus.cdb_data = 0; bus.flush = 0;
  endtask

  task automatic disp(input logic [2:0] rob, input logic r1, input logic [2:0] t1,
                      input logic [31:0] d1, input logic r2, input logic [2:0] t2,
                      input logic [31:0] d2);
    bus.dis_valid = 1; bus.dis_opcode = 5'($urandom); bus.dis_funct3 = 3'($urandom);
    bus.dis_funct7 = 1'($urandom); bus.dis_pc = $urandom; bus.dis_imm = $urandom;
    bus.dis_rob_idx = rob; bus.dis_rd = 7'($urandom);
    bus.dis_rs1_rdy = r1; bus.dis_rs1_tag = t1; bus.dis_rs1_data = d1;
    bus.dis_rs2_rdy = r2; bus.dis_rs2_tag = t2; bus.dis_rs2_data = d2;
  endtask

  task automatic cdb(input logic [2:0] tag, input logic [31:0] data);
    bus.cdb_valid = 1; bus.cdb_rob_idx = tag; bus.cdb_data = data;
  endtask

  // Check outputs for the current inputs, advance the model, step one clock.
  task automatic cyc();
    int   sel;
    bit   acc;
    ent_t e;
    iss_t l;
    sel = -1;
    #2;
    if (rst_n && !bus.flush) begin
      for (int k = 0; k < q.size(); k++) begin
        if (q[k].r1 && q[k].r2) begin sel = k; break; end
      end
    end
    chk("dis_ready", bus.dis_ready, (!rst_n || q.size() < DEPTH) ? 1 : 0);
    chk("i_valid", bus.alu_i_valid, (sel >= 0) ? 1 : 0);
    if (sel >= 0) begin
      chk("op", {bus.alu_opcode, bus.alu_funct3, bus.alu_funct7, bus.alu_i_rob_idx, bus.alu_i_rd},
          {q[sel].opcode, q[sel].f3, q[sel].f7, q[sel].rob, q[sel].rd});
      chk("pc_imm", {bus.alu_pc, bus.alu_imm}, {q[sel].pc, q[sel].imm});
      chk("src", {bus.alu_rs1_data, bus.alu_rs2_data}, {q[sel].d1, q[sel].d2});
      l.cyc = cyc_n; l.rob = bus.alu_i_rob_idx;
      l.d1 = bus.alu_rs1_data; l.d2 = bus.alu_rs2_data;
      log_q.push_back(l);
    end else begin
      chk("idle_op", {bus.alu_opcode, bus.alu_funct3, bus.alu_funct7, bus.alu_i_rob_idx, bus.alu_i_rd}, 0);
      chk("idle_pc_imm", {bus.alu_pc, bus.alu_imm}, 0);
      chk("idle_src", {bus.alu_rs1_data, bus.alu_rs2_data}, 0);
    end
    if (!rst_n || bus.flush) begin
      q.delete();
    end else begin
      acc = bus.dis_valid && (q.size() < DEPTH);
      if (sel >= 0) q.delete(sel);
      foreach (q[k]) begin
        if (bus.cdb_valid && !q[k].r1 && q[k].t1 == bus.cdb_rob_idx) begin q[k].r1 = 1; q[k].d1 = bus.cdb_data; end
        if (bus.cdb_valid && !q[k].r2 && q[k].t2 == bus.cdb_rob_idx) begin q[k].r2 = 1; q[k].d2 = bus.cdb_data; end
      end
      if (acc) begin
        e.opcode = bus.dis_opcode; e.f3 = bus.dis_funct3; e.f7 = bus.dis_funct7;
        e.pc = bus.dis_pc; e.imm = bus.dis_imm; e.rob = bus.dis_rob_idx; e.rd = bus.dis_rd;
        e.t1 = bus.dis_rs1_tag; e.t2 = bus.dis_rs2_tag;
        e.r1 = bus.dis_rs1_rdy; e.d1 = bus.dis_rs1_data;
        e.r2 = bus.dis_rs2_rdy; e.d2 = bus.dis_rs2_data;
        if (!e.r1 && bus.cdb_valid && e.t1 == bus.cdb_rob_idx) begin e.r1 = 1; e.d1 = bus.cdb_data; end
        if (!e.r2 && bus.cdb_valid && e.t2 == bus.cdb_rob_idx) begin e.r2 = 1; e.d2 = bus.cdb_data; end
        q.push_back(e);
      end
    end
    cyc_n++;
    @(posedge clk);
    @(negedge clk);
  endtask

  int c0, n0, cb;

  initial begin
    rst_n = 1;
    idle();
    #1 rst_n = 0;
    @(negedge clk);
    cyc();
    cyc();
    rst_n = 1;
    cyc();

    // ready operands issue the next cycle, then station goes idle
    n0 = log_q.size(); c0 = cyc_n;
    disp(3'd2, 1, 0, 32'd5, 1, 0, 32'd7); cyc();
    idle(); cyc(); cyc();
    chk("t31_cnt", log_q.size() - n0, 1);
    chk("t31_cyc", log_q[n0].cyc, c0 + 1);
    chk("t31_rob", log_q[n0].rob, 2);
    chk("t31_d", {log_q[n0].d1, log_q[n0].d2}, {32'd5, 32'd7});

    // wakeup: issue exactly one cycle after the broadcast
    n0 = log_q.size();
    disp(3'd3, 0, 3'd1, 0, 1, 0, 32'h9); cyc();
    idle(); cyc();
    cb = cyc_n; cdb(3'd1, 32'h10); cyc();
    idle(); cyc(); cyc();
    chk("t32_cnt", log_q.size() - n0, 1);
    chk("t32_cyc", log_q[n0].cyc, cb + 1);
    chk("t32_d1", log_q[n0].d1, 32'h10);

    // dispatch-cycle bypass from the CDB
    n0 = log_q.size(); c0 = cyc_n;
    disp(3'd5, 1, 0, 32'h1, 0, 3'd4, 32'h0); cdb(3'd4, 32'hAB); cyc();
    idle(); cyc(); cyc();
    chk("t33_cnt", log_q.size() - n0, 1);
    chk("t33_cyc", log_q[n0].cyc, c0 + 1);
    chk("t33_d2", log_q[n0].d2, 32'hAB);

    // fill, shared-tag wakeup, age-ordered issue on consecutive cycles
    n0 = log_q.size();
    for (int k = 0; k < DEPTH; k++) begin
      disp(3'(k), 0, 3'd6, 0, 1, 0, 32'(100 + k)); cyc();
    end
    disp(3'd7, 1, 0, 0, 1, 0, 0); // offered while full: ignored
    #1 chk("t34_full", bus.dis_ready, 0);
    cb = cyc_n + 1;
    cyc();
    idle(); cdb(3'd6, 32'h66); cyc();
    idle();
    for (int k = 0; k < DEPTH + 2; k++) cyc();
    chk("t34_cnt", log_q.size() - n0, DEPTH);
    for (int k = 0; k < DEPTH; k++) begin
      chk("t34_rob", log_q[n0 + k].rob, 3'(k));
      chk("t34_cyc", log_q[n0 + k].cyc, cb + 1 + k);
      chk("t34_d1", log_q[n0 + k].d1, 32'h66);
    end

    // flush with a dispatch offered: nothing survives
    n0 = log_q.size();
    for (int k = 0; k < 3; k++) begin
      disp(3'(k), 0, 3'd7, 0, 1, 0, 0); cyc();
    end
    disp(3'd4, 1, 0, 1, 1, 0, 2); bus.flush = 1;
    #1 chk("t35_flush_iv", bus.alu_i_valid, 0);
    cyc();
    idle();
    #1 chk("t35_ready", bus.dis_ready, 1);
    cyc();
    cdb(3'd7, 32'h77); cyc();
    idle(); cyc(); cyc();
    chk("t35_none", log_q.size() - n0, 0);

    // asynchronous reset with two ready entries
    n0 = log_q.size();
    disp(3'd1, 0, 3'd5, 0, 1, 0, 0); cyc();
    disp(3'd2, 0, 3'd5, 0, 1, 0, 0); cyc();
    idle(); cdb(3'd5, 32'h55); cyc();
    idle();
    #1 chk("t36_pre", bus.alu_i_valid, 1);
    rst_n = 0;
    #1 chk("t36_drop", bus.alu_i_valid, 0);
    cyc();
    rst_n = 1;
    cyc(); cyc(); cyc();
    chk("t36_none", log_q.size() - n0, 0);

    // randomized traffic against the model
    for (int it = 0; it < 600; it++) begin
      idle();
      if ($urandom_range(0, 99) < 60)
        disp(3'($urandom), 1'($urandom), 3'($urandom), $urandom,
             1'($urandom), 3'($urandom), $urandom);
      if ($urandom_range(0, 99) < 40) cdb(3'($urandom), $urandom);
      if ($urandom_range(0, 31) == 0) bus.flush = 1;
      if (!rst_n) rst_n = 1;
      else if ($urandom_range(0, 63) == 0) rst_n = 0;
      cyc();
    end
    rst_n = 1;
    idle();
    for (int k = 0; k < 4; k++) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
